fft_stage_input_sel: RTL and testbench

//  Parametrised, registered stage-input selector for the FFT datapath.
//  - Stage 0 of each frame takes beats from the scrambler; stages 1..NSTG-1 take them from the data buffer.
//  - Owns the stage/beat sequencing internally and registers the selected beat with a valid/ready handshake.
//  - Sits between the scrambler/data buffer and the butterfly array.

---
 rtl/fft_stage_input_sel.sv | 115 +++++++++++
 tb/tb_fft_stage_input_sel.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_input_sel.sv
// Stage-input selector: stage 0 of a frame draws beats from the scrambler, later stages from the data buffer.
// Latency: one cycle from an accepted input beat to out_valid; one beat per cycle when downstream is ready.
// Backpressure: a held output slot (out_valid & !out_ready) drops both input readies; data stays frozen.
module fft_stage_input_sel #(
    parameter int LANES = 8,
    parameter int DW    = 56,
    parameter int NSTG  = 8,
    parameter int BEATS = 32,
    parameter int STW   = $clog2(NSTG),
    parameter int BW    = $clog2(BEATS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                scr_valid,
    input  logic [LANES*DW-1:0] scr_data,
    output logic                scr_ready,
    input  logic                db_valid,
    input  logic [LANES*DW-1:0] db_data,
    output logic                db_ready,
    output logic                out_valid,
    output logic [LANES*DW-1:0] out_data,
    input  logic                out_ready,
    output logic [STW-1:0]      stg_cnt,
    output logic                busy,
    output logic                frame_done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [BW-1:0] beat;
    logic          sel_scr;
    logic          slot_free;
    logic          accept;
    logic          last_beat;
    logic          last_stage;
    logic          frame_end;

    // Source choice is purely a function of the stage, so it can only move at a stage boundary.
    assign sel_scr    = (stg_cnt == '0);
    assign slot_free  = !out_valid || out_ready;
    assign accept     = (scr_valid && scr_ready) || (db_valid && db_ready);
    assign last_beat  = (beat == BW'(BEATS - 1));
    assign last_stage = (stg_cnt == STW'(NSTG - 1));
    assign frame_end  = accept && last_beat && last_stage;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: start only matters in IDLE; the frame ends on the final beat's acceptance.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)     state_nxt = RUN;
            RUN:     if (frame_end) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // FSM outputs: readies never look at the matching valid, avoiding a combinational loop upstream.
    always_comb begin
        busy      = (state == RUN);
        scr_ready = busy && sel_scr && slot_free;
        db_ready  = busy && !sel_scr && slot_free;
    end

    // Stage/beat sequencing with explicit wrap compares.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_cnt <= '0;
            beat    <= '0;
        end else if (state == IDLE && start) begin
            stg_cnt <= '0;
            beat    <= '0;
        end else if (accept) begin
            if (last_beat) begin
                beat    <= '0;
                stg_cnt <= last_stage ? '0 : stg_cnt + STW'(1);
            end else begin
                beat    <= beat + BW'(1);
            end
        end
    end

    // Output slot: load on accept, drain when downstream takes it without a refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_scr ? scr_data : db_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Single-cycle end-of-frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_fft_stage_input_sel.sv
// Bench for fft_stage_input_sel: cycle model plus a data scoreboard for the default build,
// and a short directed frame on a reduced-parameter build to cover lane packing.
module tb_fft_stage_input_sel;

    localparam int LN = 8, DWD = 56, NS = 8, NB = 32, W = LN * DWD;
    localparam int SL = 4, SDW = 32, SNS = 4, SNB = 8, SW = SL * SDW;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, scr_valid, db_valid, out_ready;
    logic [W-1:0] scr_data, db_data;
    logic         scr_ready, db_ready, out_valid, busy, frame_done;
    logic [W-1:0] out_data;
    logic [2:0]   stg_cnt;

    logic          s_start, s_sv, s_dv, s_or;
    logic [SW-1:0] s_sd, s_dd, s_od;
    logic          s_sr, s_dr, s_ov, s_busy, s_fd;
    logic [1:0]    s_stg;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic         m_busy, m_ov, m_fd;
    int           m_stg, m_beat;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    fft_stage_input_sel u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .scr_valid(scr_valid), .scr_data(scr_data), .scr_ready(scr_ready),
        .db_valid(db_valid), .db_data(db_data), .db_ready(db_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .stg_cnt(stg_cnt), .busy(busy), .frame_done(frame_done)
    );

    fft_stage_input_sel #(.LANES(SL), .DW(SDW), .NSTG(SNS), .BEATS(SNB)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start),
        .scr_valid(s_sv), .scr_data(s_sd), .scr_ready(s_sr),
        .db_valid(s_dv), .db_data(s_dd), .db_ready(s_dr),
        .out_valid(s_ov), .out_data(s_od), .out_ready(s_or),
        .stg_cnt(s_stg), .busy(s_busy), .frame_done(s_fd)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_ov = 1'b0; m_fd = 1'b0; m_stg = 0; m_beat = 0;
        exp_q.delete();
    endtask

    // One clock cycle: called just after a falling edge with control inputs already set.
    task automatic step();
        logic sel, free, rs, rd, acc, nfd;
        for (int k = 0; k < LN; k++) begin
            scr_data[k*DWD +: DWD] = DWD'({$urandom(), $urandom()});
            db_data[k*DWD +: DWD]  = DWD'({$urandom(), $urandom()});
        end
        #1;
        sel  = (m_stg == 0);
        free = !m_ov || out_ready;
        rs   = m_busy && sel && free;
        rd   = m_busy && !sel && free;
        chk("scr_ready", W'(scr_ready), W'(rs));
        chk("db_ready", W'(db_ready), W'(rd));
        chk("out_valid", W'(out_valid), W'(m_ov));
        chk("busy", W'(busy), W'(m_busy));
        chk("stg_cnt", W'(stg_cnt), W'(m_stg));
        chk("frame_done", W'(frame_done), W'(m_fd));
        if (m_ov && exp_q.size() > 0) chk("out_data", out_data, exp_q[0]);
        acc = (scr_valid && rs) || (db_valid && rd);
        nfd = acc && (m_beat == NB - 1) && (m_stg == NS - 1);
        if (m_ov && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        if (acc) begin
            exp_q.push_back(sel ? scr_data : db_data);
            m_ov = 1'b1;
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        if (!m_busy && start) begin
            m_busy = 1'b1; m_stg = 0; m_beat = 0;
        end else if (acc) begin
            if (m_beat == NB - 1) begin
                m_beat = 0;
                if (m_stg == NS - 1) begin m_stg = 0; m_busy = 1'b0; end
                else m_stg++;
            end else begin
                m_beat++;
            end
        end
        m_fd = nfd;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic run_until_idle(input string tag);
        int n = 0;
        while ((m_busy || m_ov) && n < 4000) begin step(); n++; end
        step();
        chk(tag, W'(busy || out_valid), W'(0));
    endtask

    function automatic logic [SW-1:0] fpk(input int src, input int n);
        logic [SW-1:0] r;
        for (int k = 0; k < SL; k++) r[k*SDW +: SDW] = {4'(src), 4'(k), 24'(n)};
        return r;
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; scr_valid = 1'b0; db_valid = 1'b0; out_ready = 1'b0;
        scr_data = '0; db_data = '0;
        s_start = 1'b0; s_sv = 1'b0; s_dv = 1'b0; s_or = 1'b0; s_sd = '0; s_dd = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_out_data", out_data, '0);
        chk("rst_stg_cnt", W'(stg_cnt), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        rst_n = 1'b1;
        step();

        // 1: both sources always valid, downstream always ready.
        scr_valid = 1'b1; db_valid = 1'b1; out_ready = 1'b1;
        pulse_start();
        run_until_idle("t1_idle");

        // 2: downstream stall for five cycles at stage 0 beat 3.
        pulse_start();
        for (int i = 0; i < 100 && !(m_stg == 0 && m_beat == 3); i++) step();
        out_ready = 1'b0;
        repeat (5) step();
        out_ready = 1'b1;
        run_until_idle("t2_idle");

        // 3: random valids on both sources and random downstream readiness.
        pulse_start();
        for (int i = 0; i < 3000 && m_busy; i++) begin
            scr_valid = $urandom_range(0, 1) == 1;
            db_valid  = $urandom_range(0, 1) == 1;
            out_ready = $urandom_range(0, 3) != 0;
            step();
        end
        scr_valid = 1'b1; db_valid = 1'b1; out_ready = 1'b1;
        run_until_idle("t3_idle");

        // 4: start pulses mid-frame, then restart while the last beat is still held.
        pulse_start();
        for (int i = 0; i < 3000 && !m_fd; i++) begin
            start = $urandom_range(0, 3) == 0;
            step();
        end
        start = 1'b0; out_ready = 1'b0;
        pulse_start();
        repeat (3) step();
        out_ready = 1'b1;
        run_until_idle("t4_idle");

        // 5: asynchronous reset at stage 4 beat 10, then a clean frame.
        pulse_start();
        for (int i = 0; i < 3000 && !(m_stg == 4 && m_beat == 10); i++) step();
        rst_n = 1'b0;
        #1;
        chk("t5_out_valid", W'(out_valid), W'(0));
        chk("t5_stg_cnt", W'(stg_cnt), W'(0));
        chk("t5_busy", W'(busy), W'(0));
        chk("t5_frame_done", W'(frame_done), W'(0));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        pulse_start();
        run_until_idle("t5_idle");

        // 6: reduced build, one frame with known lane patterns.
        s_start = 1'b1; s_sv = 1'b1; s_dv = 1'b1; s_or = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_start = 1'b0;
        for (int n = 0; n < SNS * SNB; n++) begin
            s_sd = fpk(0, n);
            s_dd = fpk(1, n);
            @(posedge clk);
            #1;
            chk("t6_out_valid", W'(s_ov), W'(1));
            chk("t6_out_data", W'(s_od), W'(fpk(n < SNB ? 0 : 1, n)));
            chk("t6_stg_cnt", W'(s_stg), W'(((n + 1) / SNB) % SNS));
            chk("t6_frame_done", W'(s_fd), W'(n == SNS * SNB - 1));
            @(negedge clk);
        end
        chk("t6_busy_end", W'(s_busy), W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
